// File: rtl/muldiv_unit_if.sv
// Handshake/operand bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, op_i, a_i, b_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  valid_i, op_i, a_i, b_i, flush_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: fixed-latency multiply and radix-2 restoring divide,
// reporting the result in a DONE state that holds until the next accept, flush or reset.
module muldiv_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 34
) (
    input logic          clk,
    input logic          start,
    muldiv_unit_if.slave bus
);
    localparam int unsigned   CW       = 6;
    localparam int unsigned   PW       = 2 * XLEN + 2;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] ITER_LO  = CW'(DIV_CYCLES - XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] dq_q, dq_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            accept;
    logic            div_step;
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] diff;
    logic            ge;
    logic            in_sgn;
    logic [XLEN-1:0] a_mag_in, b_mag_in;
    logic            a_sgn, b_sgn;
    logic [PW-1:0]   a_sx, b_sx, prod;
    logic [XLEN-1:0] mul_res;
    logic            d_sgn, a_neg, b_neg;
    logic [XLEN-1:0] quo, rmd, div_res;

    assign accept   = (state_q != BUSY) && bus.valid_i && !bus.flush_i;
    // Iterations occupy the first XLEN busy cycles; the rest of the window just holds.
    assign div_step = (state_q == BUSY) && op_q[2] && (cnt_q >= ITER_LO);

    assign in_sgn   = ~bus.op_i[0];
    assign a_mag_in = (in_sgn && bus.a_i[XLEN-1]) ? -bus.a_i : bus.a_i;
    assign b_mag_in = (in_sgn && bus.b_i[XLEN-1]) ? -bus.b_i : bus.b_i;

    assign rem_sh = {rem_q, dq_q[XLEN-1]};
    assign diff   = {1'b0, rem_sh} - {2'b00, dvs_q};
    assign ge     = ~diff[XLEN+1];

    assign a_sgn   = op_q[0] ^ op_q[1];
    assign b_sgn   = (op_q[1:0] == 2'b01);
    assign a_sx    = {{(XLEN+2){a_sgn & a_q[XLEN-1]}}, a_q};
    assign b_sx    = {{(XLEN+2){b_sgn & b_q[XLEN-1]}}, b_q};
    assign prod    = a_sx * b_sx;
    assign mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : XLEN'(prod >> XLEN);

    assign d_sgn = ~op_q[0];
    assign a_neg = d_sgn & a_q[XLEN-1];
    assign b_neg = d_sgn & b_q[XLEN-1];

    // Zero divisor bypasses the sign fixup so signed and unsigned agree.
    always_comb begin
        if (b_q == '0) begin
            quo = '1;
            rmd = a_q;
        end else begin
            quo = (a_neg ^ b_neg) ? -dq_q : dq_q;
            rmd = a_neg ? -rem_q : rem_q;
        end
        div_res = op_q[1] ? rmd : quo;
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: if (bus.valid_i) state_d = BUSY;
                BUSY:       if (cnt_q == '0) state_d = DONE;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy_o   = (state_q == BUSY);
        bus.done_o   = (state_q == DONE);
        bus.result_o = result_q;
    end

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        dq_d     = dq_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        if (bus.flush_i) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = bus.op_i[2] ? DIV_LOAD : MUL_LOAD;
            op_d  = bus.op_i;
            a_d   = bus.a_i;
            b_d   = bus.b_i;
            dq_d  = a_mag_in;
            dvs_d = b_mag_in;
            rem_d = '0;
        end else if (state_q == BUSY) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                result_d = op_q[2] ? div_res : mul_res;
            end
            if (div_step) begin
                rem_d = ge ? XLEN'(diff) : rem_sh[XLEN-1:0];
                dq_d  = {dq_q[XLEN-2:0], ge};
            end
        end
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dq_q     <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dq_q     <= dq_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: deadline-based reference model checked every cycle,
// directed literal cases for latency/special values, then randomized traffic.
module tb_muldiv_unit;
    localparam int unsigned NMUL = 4;
    localparam int unsigned NDIV = 34;

    logic clk = 1'b0;
    logic start;
    int   vectors = 0;
    int   miscompares = 0;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32), .MUL_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
        .clk   (clk),
        .start (start),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        logic [63:0]     w;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            3'd0: begin up = ua * ub; w = up; return w[31:0]; end
            3'd1: begin sp = sa * sb; w = sp; return w[63:32]; end
            3'd2: begin up = ua * ub; w = up; return w[63:32] - (a[31] ? b : 32'h0); end
            3'd3: begin up = ua * ub; w = up; return w[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                sp = sa / sb; w = sp; return w[31:0];
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFFFFFF;
                up = ua / ub; w = up; return w[31:0];
            end
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                sp = sa % sb; w = sp; return w[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                up = ua % ub; w = up; return w[31:0];
            end
        endcase
    endfunction

    // Reference: an accepted op finishes exactly N edges later unless flushed or reset.
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    bit          m_rst  = 1'b1;
    logic [31:0] m_res  = 32'h0;
    logic [31:0] m_pend = 32'h0;
    int          m_edge = 0;
    int          m_deadline = 0;

    always @(posedge clk or negedge start) begin
        if (!start) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_res  = 32'h0;
            m_rst  = 1'b1;
        end else begin
            m_edge++;
            m_rst = 1'b0;
            if (bus.flush_i) begin
                m_busy = 1'b0;
                m_done = 1'b0;
            end else if (m_busy) begin
                if (m_edge == m_deadline) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_res  = m_pend;
                end
            end else if (bus.valid_i) begin
                m_busy     = 1'b1;
                m_done     = 1'b0;
                m_pend     = ref_op(bus.op_i, bus.a_i, bus.b_i);
                m_deadline = m_edge + (bus.op_i[2] ? NDIV : NMUL);
            end
        end
    end

    always @(negedge clk) begin
        check("busy_o", {31'h0, bus.busy_o}, {31'h0, m_busy});
        check("done_o", {31'h0, bus.done_o}, {31'h0, m_done});
        if (m_done || m_rst) check("result_o", bus.result_o, m_res);
    end

    task automatic wait_done(input int n, input logic [31:0] exp, input string nm);
        int k;
        k = 0;
        while (!bus.done_o && k < 80) begin
            @(posedge clk); #1;
            k++;
        end
        check({nm, "_latency"}, k, n);
        check(nm, bus.result_o, exp);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string nm);
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        wait_done(op[2] ? NDIV : NMUL, exp, nm);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 7)
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k;
        start       = 1'b1;
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.op_i    = 3'd0;
        bus.a_i     = 32'h0;
        bus.b_i     = 32'h0;
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, bus.busy_o}, 32'h0);
        check("rst_done", {31'h0, bus.done_o}, 32'h0);
        check("rst_result", bus.result_o, 32'h0);
        start = 1'b1;

        check("model_mulh", ref_op(3'd1, 32'h80000000, 32'h80000000), 32'h40000000);
        check("model_mulhsu", ref_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
        check("model_div", ref_op(3'd4, 32'hFFFFFFF9, 32'h2), 32'hFFFFFFFD);

        run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "mulh");
        run_op(3'd0, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, "mul");
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
        run_op(3'd4, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, "div_neg");
        run_op(3'd6, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, "rem_neg");
        run_op(3'd5, 32'h12345678, 32'h0, 32'hFFFFFFFF, "divu_zero");
        run_op(3'd7, 32'h12345678, 32'h0, 32'h12345678, "remu_zero");
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, "rem_ovf");
        run_op(3'd4, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFF, "div_zero");
        run_op(3'd6, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, "rem_zero");

        // Flush during a divide, then a multiply accepted at cycle 12.
        bus.valid_i = 1'b1; bus.op_i = 3'd4; bus.a_i = 32'd1000; bus.b_i = 32'd3;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        check("flush_busy", {31'h0, bus.busy_o}, 32'h0);
        check("flush_done", {31'h0, bus.done_o}, 32'h0);
        run_op(3'd0, 32'd3, 32'd5, 32'd15, "mul_after_flush");

        // Asynchronous reset in the middle of a divide.
        bus.valid_i = 1'b1; bus.op_i = 3'd5; bus.a_i = 32'd999; bus.b_i = 32'd7;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #3 start = 1'b0;
        #1;
        check("arst_busy", {31'h0, bus.busy_o}, 32'h0);
        check("arst_done", {31'h0, bus.done_o}, 32'h0);
        check("arst_result", bus.result_o, 32'h0);
        @(posedge clk); #1;
        start = 1'b1;
        run_op(3'd3, 32'hFFFFFFFF, 32'h2, 32'h1, "first_after_reset");
        repeat (40) @(posedge clk);
        #1;

        // valid held through BUSY with changing operands, then back-to-back from DONE.
        bus.valid_i = 1'b1; bus.op_i = 3'd5; bus.a_i = 32'd100; bus.b_i = 32'd7;
        @(posedge clk); #1;
        k = 0;
        while (!bus.done_o && k < 80) begin
            bus.op_i = 3'($urandom);
            bus.a_i  = $urandom;
            bus.b_i  = $urandom;
            @(posedge clk); #1;
            k++;
        end
        check("hold_latency", k, NDIV);
        check("hold_result", bus.result_o, 32'd14);
        run_op(3'd7, 32'd100, 32'd7, 32'd2, "b2b_remu");

        for (int c = 0; c < 3000; c++) begin
            bus.valid_i = ($urandom % 5) < 2;
            bus.flush_i = ($urandom % 50) == 0;
            bus.op_i    = 3'($urandom);
            bus.a_i     = pick();
            bus.b_i     = pick();
            @(posedge clk); #1;
        end
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter MUL_CYCLES, default MUL_COUNT (riscv_defines), multiply latency in cycles, legal range 1..63.
REQ-003 SHALL have parameter DIV_CYCLES, default DIV_COUNT (riscv_defines), divide latency in cycles, legal range 33..63.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 start  input  1  reset, asynchronous, active-low; start=0 forces reset state immediately.
REQ-006 valid_i  input  1  EX-stage fire of a MUL/DIV-class instruction; samples op_i, a_i, b_i.
REQ-007 op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 a_i  input  XLEN  rs1 operand.
REQ-009 b_i  input  XLEN  rs2 operand.
REQ-010 flush_i  input  1  EX flush; aborts any operation in progress.
REQ-011 busy_o  output  1  operation accepted and not yet complete.
REQ-012 done_o  output  1  result_o valid; level, held until next accept, flush or reset.
REQ-013 result_o  output  XLEN  selected result.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 Accept: valid_i=1 in IDLE or DONE with flush_i=0 -> latch op/operands, load counter with (MUL_CYCLES or DIV_CYCLES)-1, go to BUSY; edge of acceptance is cycle 0.
REQ-016 valid_i while BUSY SHALL be ignored; latched operands unchanged.
REQ-017 BUSY: counter decrements once per cycle; at counter 0 the next edge moves to DONE.
REQ-018 done_o SHALL assert in exactly cycle N after acceptance (N = MUL_CYCLES for op_i[2]=0, DIV_CYCLES for op_i[2]=1), matching the EX stall window of N cycles.
REQ-019 busy_o=1 exactly in BUSY; done_o=1 exactly in DONE; never both.
REQ-020 MUL: low XLEN bits of a*b; MULH: high XLEN bits, signed x signed; MULHSU: signed a x unsigned b; MULHU: unsigned x unsigned; computed from a 2*XLEN+2-bit product of sign/zero-extended operands.
REQ-021 DIV/DIVU/REM/REMU: radix-2 restoring division on magnitudes, one quotient bit per cycle, XLEN iterations; sign fixup (quotient negated if signs differ, remainder takes dividend sign) before DONE.
REQ-022 Divisor zero: quotient = all ones, remainder = a_i, for signed and unsigned.
REQ-023 Signed overflow (a = -2^(XLEN-1), b = -1): DIV result -2^(XLEN-1), REM result 0.
REQ-024 Special cases of REQ-022/023 SHALL keep the same fixed latency N.
REQ-025 If iteration completes before counter reaches 0, the result SHALL be held internally; result_o content outside DONE is don't-care but SHALL NOT be X after reset.
REQ-026 flush_i=1 SHALL return to IDLE next edge from any state and clear done_o; takes priority over valid_i in the same cycle.
REQ-027 Accept in DONE: done_o drops the cycle after acceptance; new result replaces old at cycle N.

Reset
REQ-028 start=0 SHALL asynchronously force IDLE, counter 0, busy_o=0, done_o=0, result_o=0, internal operand/accumulator registers 0.
REQ-029 Reset mid-BUSY SHALL abandon the operation; after start returns 1 the unit is IDLE and no done_o is produced for the abandoned op.
REQ-030 valid_i in the first edge after start rises SHALL be accepted normally.

Verification
REQ-031 MULH a=0x80000000, b=0x80000000, MUL_CYCLES=4 -> busy_o cycles 0..3, done_o at cycle 4, result_o=0x40000000.
REQ-032 DIV a=0xFFFFFFF9 (-7), b=2, DIV_CYCLES=34 -> done_o at cycle 34, result_o=0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-033 DIVU a=0x12345678, b=0 -> result_o=0xFFFFFFFF; REMU -> 0x12345678; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0; all at cycle 34.
REQ-034 DIV accepted, flush_i=1 at cycle 10 -> IDLE at cycle 11, done_o never asserts; MUL accepted cycle 12 completes normally.
REQ-035 start=0 pulsed asynchronously at cycle 5 of DIV -> outputs 0 immediately; no done_o follows.
REQ-036 valid_i held high through BUSY with changing operands -> result reflects cycle-0 operands only; back-to-back accept from DONE produces second result at its own cycle N.
